// File: rtl/em_stage.sv
// Execute->memory/writeback stage of the 3-stage RV32 core: one outstanding dmem access, load formatting, stall.
// Optional stall counter output stall_cnt_o is enabled by defining EM_PERF_CNT_EN.
module em_stage #(
  parameter int XLEN = 32,
  parameter int REGW = 5
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_e,
  input  logic              flush_i,
  input  logic [REGW-1:0]   rd_e,
  input  logic              reg_write_e,
  input  logic              mem_read_e,
  input  logic              mem_write_e,
  input  logic [2:0]        funct3_e,
  input  logic [XLEN-1:0]   alu_result_e,
  input  logic [XLEN-1:0]   store_data_e,
  output logic              stall_o,
  output logic [REGW-1:0]   rd_m,
  output logic              reg_write_m,
  output logic [XLEN-1:0]   result_m,
  output logic              misalign_o,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [XLEN-1:0]   dmem_addr_o,
  output logic [XLEN-1:0]   dmem_wdata_o,
  output logic [XLEN/8-1:0] dmem_be_o,
  input  logic              dmem_rvalid_i,
  input  logic [XLEN-1:0]   dmem_rdata_i
`ifdef EM_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cnt_o
`endif
);

  localparam int BW = XLEN / 8;

  typedef enum logic [1:0] {ST_EMPTY, ST_ALU, ST_MEM_WAIT} state_t;

  state_t            state_q, state_d;
  logic [REGW-1:0]   rd_q;
  logic              reg_write_q;
  logic              is_load_q;
  logic [2:0]        funct3_q;
  logic [1:0]        lane_q;
  logic [XLEN-1:0]   result_q;
  logic              misalign_q;
  logic              we_q;
  logic [XLEN-1:0]   addr_q;
  logic [XLEN-1:0]   wdata_q;
  logic [BW-1:0]     be_q;

  // Capture-side decode of the execute slot.
  logic            take, mem_op, is_store_e, misalign_e, go_mem;
  logic [BW-1:0]   lane_mask, be_e;
  logic [XLEN-1:0] wdata_e;

  assign take       = valid_e & ~flush_i;
  assign mem_op     = mem_read_e | mem_write_e;
  assign is_store_e = mem_write_e & ~mem_read_e;   // load wins when both are set

  // NOTE: every signal written in an always_comb gets a default first, so no path can infer a latch.
  always_comb begin
    misalign_e = 1'b0;
    lane_mask  = '1;
    wdata_e    = store_data_e;
    unique case (funct3_e[1:0])
      2'b00: begin
        lane_mask = {{(BW-1){1'b0}}, 1'b1};
        wdata_e   = {BW{store_data_e[7:0]}};
      end
      2'b01: begin
        misalign_e = alu_result_e[0];
        lane_mask  = {{(BW-2){1'b0}}, 2'b11};
        wdata_e    = {(BW/2){store_data_e[15:0]}};
      end
      default: misalign_e = |alu_result_e[1:0];
    endcase
  end

  assign be_e   = lane_mask << alu_result_e[1:0];
  assign go_mem = take & mem_op & ~misalign_e;

  assign stall_o = (state_q == ST_MEM_WAIT) & ~dmem_rvalid_i;

  always_comb begin
    state_d = state_q;
    if (!stall_o) begin
      if (!take)       state_d = ST_EMPTY;
      else if (go_mem) state_d = ST_MEM_WAIT;
      else             state_d = ST_ALU;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: all datapath registers are asynchronously cleared so outputs read 0 straight out of reset.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      rd_q        <= '0;
      reg_write_q <= 1'b0;
      is_load_q   <= 1'b0;
      funct3_q    <= '0;
      lane_q      <= '0;
      result_q    <= '0;
      misalign_q  <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      be_q        <= '0;
    end else if (!stall_o) begin
      rd_q        <= take ? rd_e : '0;
      // Misaligned memory ops land in ALU state with the write suppressed.
      reg_write_q <= take & reg_write_e & ~mem_op & (|rd_e);
      is_load_q   <= go_mem & mem_read_e;
      funct3_q    <= funct3_e;
      lane_q      <= alu_result_e[1:0];
      result_q    <= take ? alu_result_e : '0;
      misalign_q  <= take & mem_op & misalign_e;
      we_q        <= go_mem & is_store_e;
      addr_q      <= go_mem ? {alu_result_e[XLEN-1:2], 2'b00} : '0;
      wdata_q     <= (go_mem & is_store_e) ? wdata_e : '0;
      be_q        <= (go_mem & is_store_e) ? be_e : '0;
    end
  end

  // Load formatting from the captured size/sign and byte lane.
  logic [XLEN-1:0] byte_sh, half_sh, load_fmt;
  assign byte_sh = dmem_rdata_i >> {lane_q, 3'b000};
  assign half_sh = dmem_rdata_i >> {lane_q[1], 4'b0000};

  always_comb begin
    load_fmt = dmem_rdata_i;
    unique case (funct3_q)
      3'b000:  load_fmt = {{(XLEN-8){byte_sh[7]}}, byte_sh[7:0]};
      3'b001:  load_fmt = {{(XLEN-16){half_sh[15]}}, half_sh[15:0]};
      3'b100:  load_fmt = {{(XLEN-8){1'b0}}, byte_sh[7:0]};
      3'b101:  load_fmt = {{(XLEN-16){1'b0}}, half_sh[15:0]};
      default: load_fmt = dmem_rdata_i;
    endcase
  end

  always_comb begin
    reg_write_m = 1'b0;
    result_m    = '0;
    unique case (state_q)
      ST_ALU: begin
        reg_write_m = reg_write_q;
        result_m    = result_q;
      end
      ST_MEM_WAIT: begin
        if (dmem_rvalid_i && is_load_q) begin
          reg_write_m = |rd_q;
          result_m    = load_fmt;
        end
      end
      default: ;
    endcase
  end

  assign rd_m         = rd_q;
  assign misalign_o   = misalign_q;
  assign dmem_req_o   = (state_q == ST_MEM_WAIT);
  assign dmem_we_o    = we_q;
  assign dmem_addr_o  = addr_q;
  assign dmem_wdata_o = wdata_q;
  assign dmem_be_o    = be_q;

`ifdef EM_PERF_CNT_EN
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      stall_cnt_o <= '0;
    end else if (stall_o && stall_cnt_o != 32'hFFFF_FFFF) begin
      stall_cnt_o <= stall_cnt_o + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_em_stage.sv
// Self-checking bench for em_stage: directed test-plan steps plus randomized ops against an arithmetic model.
module tb_em_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_e, flush_i, reg_write_e, mem_read_e, mem_write_e;
  logic [4:0]  rd_e;
  logic [2:0]  funct3_e;
  logic [31:0] alu_result_e, store_data_e;
  logic        stall_o, reg_write_m, misalign_o, dmem_req_o, dmem_we_o;
  logic [4:0]  rd_m;
  logic [31:0] result_m, dmem_addr_o, dmem_wdata_o;
  logic [3:0]  dmem_be_o;
  logic        dmem_rvalid_i;
  logic [31:0] dmem_rdata_i;
`ifdef EM_PERF_CNT_EN
  logic [31:0] stall_cnt_o;
`endif

  int n_tests = 0;
  int n_fail  = 0;
  int exp_stall = 0;

  em_stage #(.XLEN(32), .REGW(5)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_e(valid_e), .flush_i(flush_i),
    .rd_e(rd_e), .reg_write_e(reg_write_e), .mem_read_e(mem_read_e),
    .mem_write_e(mem_write_e), .funct3_e(funct3_e), .alu_result_e(alu_result_e),
    .store_data_e(store_data_e), .stall_o(stall_o), .rd_m(rd_m),
    .reg_write_m(reg_write_m), .result_m(result_m), .misalign_o(misalign_o),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_be_o(dmem_be_o),
    .dmem_rvalid_i(dmem_rvalid_i), .dmem_rdata_i(dmem_rdata_i)
`ifdef EM_PERF_CNT_EN
    , .stall_cnt_o(stall_cnt_o)
`endif
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: access rules expressed as plain arithmetic.
  function automatic int unsigned size_of(input logic [2:0] f3);
    return (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit is_misaligned(input logic [2:0] f3, input logic [31:0] addr);
    return (addr % size_of(f3)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] f3, input logic [31:0] addr,
                                             input logic [31:0] word);
    longint v;
    int unsigned lane = addr % 4;
    case (f3)
      3'd0: begin v = (word >> (8 * lane)) & 255; if (v >= 128) v -= 256; end
      3'd4: v = (word >> (8 * lane)) & 255;
      3'd1: begin v = (word >> (16 * (lane / 2))) & 65535; if (v >= 32768) v -= 65536; end
      3'd5: v = (word >> (16 * (lane / 2))) & 65535;
      default: v = word;
    endcase
    return v[31:0];
  endfunction

  function automatic logic [31:0] model_be(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned sz = size_of(f3);
    return ((32'd1 << sz) - 32'd1) << (addr % 4);
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] f3, input logic [31:0] d);
    if (size_of(f3) == 1) return (d & 32'hFF) * 32'h0101_0101;
    if (size_of(f3) == 2) return (d & 32'hFFFF) * 32'h0001_0001;
    return d;
  endfunction

  task automatic check_idle(input string tag);
    check({tag, "_idle_rd"}, 32'(rd_m), 32'd0);
    check({tag, "_idle_rw"}, 32'(reg_write_m), 32'd0);
    check({tag, "_idle_mis"}, 32'(misalign_o), 32'd0);
    check({tag, "_idle_req"}, 32'(dmem_req_o), 32'd0);
    check({tag, "_idle_stall"}, 32'(stall_o), 32'd0);
  endtask

  // Issue one instruction at the next edge and follow it to retirement.
  task automatic do_op(input string tag, input bit v, input bit fl, input logic [4:0] rd,
                       input bit rw, input bit mr, input bit mw, input logic [2:0] f3,
                       input logic [31:0] addr, input logic [31:0] sd, input int delay,
                       input logic [31:0] rdata, input bit flush_during);
    bit taken    = v && !fl;
    bit memop    = mr || mw;
    bit misal    = memop && is_misaligned(f3, addr);
    bit is_load  = mr;
    valid_e = v; flush_i = fl; rd_e = rd; reg_write_e = rw; mem_read_e = mr;
    mem_write_e = mw; funct3_e = f3; alu_result_e = addr; store_data_e = sd;
    dmem_rvalid_i = 1'b0;
    @(posedge clk_i); #1;
    valid_e = 1'b0; flush_i = 1'b0;
    if (!taken) begin
      #1;
      check({tag, "_bub_rd"}, 32'(rd_m), 32'd0);
      check({tag, "_bub_rw"}, 32'(reg_write_m), 32'd0);
      check({tag, "_bub_req"}, 32'(dmem_req_o), 32'd0);
    end else if (!memop || misal) begin
      #1;
      check({tag, "_alu_rd"}, 32'(rd_m), 32'(rd));
      check({tag, "_alu_rw"}, 32'(reg_write_m), 32'(!memop && rw && rd != 0));
      check({tag, "_alu_res"}, result_m, addr);
      check({tag, "_alu_mis"}, 32'(misalign_o), 32'(misal));
      check({tag, "_alu_req"}, 32'(dmem_req_o), 32'd0);
      check({tag, "_alu_stall"}, 32'(stall_o), 32'd0);
    end else begin
      for (int c = 0; c <= delay; c++) begin
        if (c < delay) begin
          dmem_rvalid_i = 1'b0;
          if (flush_during) begin
            valid_e = 1'b1; flush_i = 1'b1; rd_e = 5'd7; reg_write_e = 1'b1;
            mem_read_e = 1'b0; mem_write_e = 1'b0; alu_result_e = 32'hDEAD_0000;
          end
          #1;
          check({tag, "_wait_stall"}, 32'(stall_o), 32'd1);
          check({tag, "_wait_rw"}, 32'(reg_write_m), 32'd0);
        end else begin
          valid_e = 1'b0; flush_i = 1'b0;
          dmem_rvalid_i = 1'b1; dmem_rdata_i = rdata;
          #1;
          check({tag, "_ret_stall"}, 32'(stall_o), 32'd0);
          check({tag, "_ret_rw"}, 32'(reg_write_m), 32'(is_load && rd != 0));
          if (is_load) check({tag, "_ret_res"}, result_m, model_load(f3, addr, rdata));
        end
        check({tag, "_req"}, 32'(dmem_req_o), 32'd1);
        check({tag, "_we"}, 32'(dmem_we_o), 32'(!is_load));
        check({tag, "_addr"}, dmem_addr_o, addr & 32'hFFFF_FFFC);
        check({tag, "_be"}, 32'(dmem_be_o), is_load ? 32'd0 : model_be(f3, addr));
        if (!is_load) check({tag, "_wdata"}, dmem_wdata_o, model_wdata(f3, sd));
        check({tag, "_rd"}, 32'(rd_m), 32'(rd));
        @(posedge clk_i); #1;
      end
      dmem_rvalid_i = 1'b0;
      exp_stall += delay;
`ifdef EM_PERF_CNT_EN
      check({tag, "_stallcnt"}, stall_cnt_o, 32'(exp_stall));
`endif
      check_idle(tag);
      return;
    end
    @(posedge clk_i); #1;
    #1;
    check_idle(tag);
  endtask

  initial begin
    valid_e = 0; flush_i = 0; rd_e = 0; reg_write_e = 0; mem_read_e = 0; mem_write_e = 0;
    funct3_e = 0; alu_result_e = 0; store_data_e = 0; dmem_rvalid_i = 0; dmem_rdata_i = 0;
    rst_i = 1'b0;
    #2;
    check("rst_stall", 32'(stall_o), 32'd0);
    check("rst_rw", 32'(reg_write_m), 32'd0);
    check("rst_req", 32'(dmem_req_o), 32'd0);
    check("rst_mis", 32'(misalign_o), 32'd0);
    check("rst_rd", 32'(rd_m), 32'd0);
    check("rst_res", result_m, 32'd0);
    check("rst_addr", dmem_addr_o, 32'd0);
    check("rst_be", 32'(dmem_be_o), 32'd0);
`ifdef EM_PERF_CNT_EN
    check("rst_stallcnt", stall_cnt_o, 32'd0);
`endif
    @(posedge clk_i); #2;
    rst_i = 1'b1;

    // Directed test-plan steps.
    do_op("alu", 1, 0, 5'd5, 1, 0, 0, 3'd0, 32'h1234, 32'h0, 0, 32'h0, 0);
    do_op("lb", 1, 0, 5'd9, 1, 1, 0, 3'd0, 32'h1003, 32'h0, 3, 32'h80FF_FFFF, 0);
    do_op("sh", 1, 0, 5'd4, 0, 0, 1, 3'd1, 32'h2002, 32'hABCD, 2, 32'h0, 0);
    do_op("lw_mis", 1, 0, 5'd6, 1, 1, 0, 3'd2, 32'h3001, 32'h0, 0, 32'h0, 0);
    do_op("flush", 1, 1, 5'd8, 1, 0, 0, 3'd0, 32'h55, 32'h0, 0, 32'h0, 0);
    do_op("lh_flstall", 1, 0, 5'd10, 1, 1, 0, 3'd1, 32'h4002, 32'h0, 3, 32'h8001_1234, 1);
    do_op("lw_imm", 1, 0, 5'd11, 1, 1, 0, 3'd2, 32'h5000, 32'h0, 0, 32'hCAFE_F00D, 0);
    do_op("both_rw", 1, 0, 5'd12, 1, 1, 1, 3'd4, 32'h6001, 32'h77, 1, 32'h1122_F344, 0);
    do_op("lw_rd0", 1, 0, 5'd0, 1, 1, 0, 3'd2, 32'h7000, 32'h0, 1, 32'h1, 0);

    // Reset while a load is outstanding.
    valid_e = 1; rd_e = 5'd3; reg_write_e = 1; mem_read_e = 1; mem_write_e = 0;
    funct3_e = 3'd2; alu_result_e = 32'h40;
    @(posedge clk_i); #1;
    valid_e = 0; #1;
    check("mid_req_before", 32'(dmem_req_o), 32'd1);
    rst_i = 1'b0; #1;
    check("mid_req_async", 32'(dmem_req_o), 32'd0);
    check("mid_stall_async", 32'(stall_o), 32'd0);
    check("mid_rd_async", 32'(rd_m), 32'd0);
    exp_stall = 0;
`ifdef EM_PERF_CNT_EN
    check("mid_stallcnt", stall_cnt_o, 32'd0);
`endif
    #1 rst_i = 1'b1;
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b1; dmem_rdata_i = 32'hFFFF_FFFF; #1;
    check("stale_rw", 32'(reg_write_m), 32'd0);
    check("stale_stall", 32'(stall_o), 32'd0);
    check("stale_res", result_m, 32'd0);
    @(posedge clk_i); #1;
    dmem_rvalid_i = 1'b0;

    // Randomized ops.
    for (int i = 0; i < 60; i++) begin
      int unsigned kind = $urandom_range(0, 5);
      logic [4:0]  rd   = 5'($urandom_range(0, 31));
      logic [31:0] base = $urandom & 32'hFFFF_FFFC;
      logic [31:0] sd   = $urandom;
      logic [31:0] rdat = $urandom;
      int          dly  = $urandom_range(0, 3);
      logic [2:0]  f3;
      case (kind)
        0: do_op("r_alu", 1, 0, rd, 1'($urandom), 0, 0, 3'd0, $urandom, sd, 0, 0, 0);
        1: begin
          logic [2:0] lf[5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
          f3 = lf[$urandom_range(0, 4)];
          base = base + ((size_of(f3) == 1) ? $urandom_range(0, 3) :
                         (size_of(f3) == 2) ? 2 * $urandom_range(0, 1) : 0);
          do_op("r_ld", 1, 0, rd, 1, 1, 0, f3, base, sd, dly, rdat, 1'($urandom));
        end
        2: begin
          f3 = 3'($urandom_range(0, 2));
          base = base + ((size_of(f3) == 1) ? $urandom_range(0, 3) :
                         (size_of(f3) == 2) ? 2 * $urandom_range(0, 1) : 0);
          do_op("r_st", 1, 0, rd, 0, 0, 1, f3, base, sd, dly, rdat, 0);
        end
        3: begin
          f3 = ($urandom_range(0, 1) == 1) ? 3'd2 : 3'd1;
          base = base + ((f3 == 3'd2) ? $urandom_range(1, 3) : 1 + 2 * $urandom_range(0, 1));
          do_op("r_mis", 1, 0, rd, 1, 1'($urandom), 1, f3, base, sd, 0, 0, 0);
        end
        4: do_op("r_bub", 0, 0, rd, 1, 0, 0, 3'd0, base, sd, 0, 0, 0);
        default: do_op("r_fl", 1, 1, rd, 1, 1, 0, 3'd2, base, sd, 0, 0, 0);
      endcase
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, %0d checks run", n_tests);
    $fatal(1, "timeout");
  end

endmodule
